// File: rtl/fetch_group_gen_pkg.sv
// Shared front-end definitions for the fetch group generator: widths, FSM states
// and line-address helpers.
package fetch_group_gen_pkg;

    localparam int FETCH_WIDTH     = 128;
    localparam int INSTS_PER_GROUP = 4;
    localparam int GROUP_BYTES     = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        DELIVER = 3'd3,
        DROP    = 3'd4
    } fetch_state_e;

    function automatic logic [63:0] line_addr(input logic [63:0] addr);
        return {addr[63:4], 4'b0000};
    endfunction

    // Start of the following line; wraps to 0 past the top of the address space.
    function automatic logic [63:0] next_line(input logic [63:0] addr);
        return line_addr(addr) + 64'(GROUP_BYTES);
    endfunction

endpackage

// File: rtl/fetch_group_packer.sv
// Combinational packer: shifts a fetched line so the word at the fetch offset
// lands in slot 0, and produces the matching low-contiguous valid mask.
module fetch_group_packer
    import fetch_group_gen_pkg::*;
(
    input  logic [FETCH_WIDTH-1:0]     line_data_i,
    input  logic [1:0]                 off_i,
    output logic [FETCH_WIDTH-1:0]     instr_o,
    output logic [INSTS_PER_GROUP-1:0] valid_o
);

    // Shift out the words before the fetch PC and build the valid mask.
    always_comb begin
        instr_o = line_data_i >> {off_i, 5'b00000};
        case (off_i)
            2'd0:    valid_o = 4'b1111;
            2'd1:    valid_o = 4'b0111;
            2'd2:    valid_o = 4'b0011;
            2'd3:    valid_o = 4'b0001;
            default: valid_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/fetch_group_gen.sv
// Fetch group generator: walks the fetch PC, requests aligned lines from the icache
// and hands one packed group to the instruction buffer per request.
module fetch_group_gen
    import fetch_group_gen_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0000_0000_8000_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       fetch_inst,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_target,
    output logic                       icache_req_valid,
    input  logic                       icache_req_ready,
    output logic [63:0]                icache_req_addr,
    input  logic                       icache_resp_valid,
    input  logic [FETCH_WIDTH-1:0]     icache_resp_data,
    output logic [FETCH_WIDTH-1:0]     aligned_instr,
    output logic [INSTS_PER_GROUP-1:0] aligned_instr_valid,
    output logic [63:0]                pc
);

    localparam int CD_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(DRAIN_CYCLES - 1);

    fetch_state_e               state_q, state_d;
    logic [63:0]                fpc_q, fpc_d;
    logic [CD_W-1:0]            cd_q, cd_d;
    logic                       req_valid_q, req_valid_d;
    logic [63:0]                req_addr_q, req_addr_d;
    logic [FETCH_WIDTH-1:0]     instr_q, instr_d;
    logic [INSTS_PER_GROUP-1:0] valid_q, valid_d;
    logic [63:0]                pc_q, pc_d;

    logic [FETCH_WIDTH-1:0]     pk_instr_s;
    logic [INSTS_PER_GROUP-1:0] pk_valid_s;

    fetch_group_packer u_packer (
        .line_data_i (icache_resp_data),
        .off_i       (fpc_q[3:2]),
        .instr_o     (pk_instr_s),
        .valid_o     (pk_valid_s)
    );

    // Next-state logic; a redirect overrides every other event in each state.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        cd_d    = (cd_q != '0) ? (cd_q - CD_W'(1)) : '0;
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = 4'b0000;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fpc_d = redirect_target;
                    cd_d  = '0;
                end else if (fetch_inst && (cd_q == '0)) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fpc_d   = redirect_target;
                    state_d = icache_req_ready ? DROP : REQ;
                end else if (icache_req_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    fpc_d   = redirect_target;
                    state_d = icache_resp_valid ? REQ : DROP;
                end else if (icache_resp_valid) begin
                    state_d = DELIVER;
                    instr_d = pk_instr_s;
                    valid_d = pk_valid_s;
                    pc_d    = fpc_q;
                end else begin
                    state_d = WAIT;
                end
            end
            DELIVER: begin
                if (redirect_valid) begin
                    fpc_d   = redirect_target;
                    state_d = REQ;
                end else begin
                    fpc_d   = next_line(fpc_q);
                    cd_d    = CD_LOAD;
                    state_d = IDLE;
                end
            end
            DROP: begin
                // A response landing with a redirect still belongs to the dead request.
                if (redirect_valid) begin
                    fpc_d   = redirect_target;
                    state_d = icache_resp_valid ? REQ : DROP;
                end else if (icache_resp_valid) begin
                    state_d = REQ;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_valid_d = (state_d == REQ);
        req_addr_d  = (state_d == REQ) ? line_addr(fpc_d) : 64'd0;
    end

    // State and registered output update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            fpc_q       <= RESET_PC;
            cd_q        <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= 64'd0;
            instr_q     <= '0;
            valid_q     <= 4'b0000;
            pc_q        <= 64'd0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            cd_q        <= cd_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
        end
    end

    assign icache_req_valid    = req_valid_q;
    assign icache_req_addr     = req_addr_q;
    assign aligned_instr       = instr_q;
    assign pc                  = pc_q;
    // A redirect in the delivery cycle cancels the group the buffer would take.
    assign aligned_instr_valid = valid_q & {INSTS_PER_GROUP{~redirect_valid}};

endmodule

// File: tb/tb_fetch_group_gen.sv
// Randomized bench for fetch_group_gen: an icache responder plus a transaction-level
// model of requests, deliveries and redirects.
module tb_fetch_group_gen;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          DRAIN    = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         fetch_inst;
    logic         redirect_valid;
    logic [63:0]  redirect_target;
    logic         icache_req_valid;
    logic         icache_req_ready;
    logic [63:0]  icache_req_addr;
    logic         icache_resp_valid;
    logic [127:0] icache_resp_data;
    logic [127:0] aligned_instr;
    logic [3:0]   aligned_instr_valid;
    logic [63:0]  pc;

    fetch_group_gen #(.RESET_PC(RESET_PC), .DRAIN_CYCLES(DRAIN)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .fetch_inst          (fetch_inst),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .icache_req_valid    (icache_req_valid),
        .icache_req_ready    (icache_req_ready),
        .icache_req_addr     (icache_req_addr),
        .icache_resp_valid   (icache_resp_valid),
        .icache_resp_data    (icache_resp_data),
        .aligned_instr       (aligned_instr),
        .aligned_instr_valid (aligned_instr_valid),
        .pc                  (pc)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model state: one outstanding line request and a pending delivery.
    bit           outst, live, pend;
    int           due_cyc, cyc, last_deliv;
    int           deliv_count, hs_count;
    logic [127:0] rdata, p_instr;
    logic [3:0]   p_mask;
    logic [63:0]  p_pc, exp_fpc, last_hs_addr;

    // Stimulus knobs.
    int           redir_pct, lat_lo, lat_hi;
    bit           calm, force_redir;
    logic [63:0]  force_tgt;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        case ($urandom_range(0, 4))
            0:       t = 64'h0000_0000_8000_0108;
            1:       t = 64'h0000_0000_9000_0004;
            2:       t = 64'hFFFF_FFFF_FFFF_FFF4;
            default: t = {32'($urandom), 32'($urandom)};
        endcase
        t[1:0] = 2'b00;
        return t;
    endfunction

    task automatic drive_inputs();
        int pct;
        fetch_inst        = calm ? 1'b1 : ($urandom_range(0, 9) != 0);
        icache_req_ready  = calm ? 1'b1 : ($urandom_range(0, 3) != 0);
        icache_resp_valid = outst && (cyc == due_cyc);
        icache_resp_data  = icache_resp_valid ? rdata : {4{32'($urandom)}};
        pct = (pend || icache_resp_valid) ? redir_pct * 4 : redir_pct;
        redirect_valid    = force_redir || (32'($urandom_range(0, 99)) < 32'(pct));
        redirect_target   = force_redir ? force_tgt : pick_target();
    endtask

    // Model: one cycle of observation at the falling edge.
    task automatic observe();
        bit was_pend;
        int off;
        was_pend = pend;
        if (pend) begin
            if (redirect_valid) begin
                check_val("cancelled_valid", aligned_instr_valid, 4'b0000);
            end else begin
                check_val("group_valid", aligned_instr_valid, p_mask);
                check_val("group_instr", aligned_instr, p_instr);
                check_val("group_pc", pc, p_pc);
                check_val("spacing_ok", (cyc - last_deliv) >= DRAIN, 1'b1);
                last_deliv = cyc;
                deliv_count++;
                exp_fpc = {exp_fpc[63:4], 4'h0} + 64'd16;
            end
            pend = 1'b0;
        end else begin
            check_val("no_group", aligned_instr_valid, 4'b0000);
        end
        if (outst || was_pend)
            check_val("single_outstanding", icache_req_valid, 1'b0);
        if (redirect_valid && outst)
            live = 1'b0;
        if (icache_resp_valid) begin
            outst = 1'b0;
            if (live && !redirect_valid) begin
                off = int'(exp_fpc[3:2]);
                p_instr = '0;
                for (int k = 0; k < 4; k++)
                    if (k + off < 4) p_instr[32*k +: 32] = rdata[32*(k+off) +: 32];
                p_mask = 4'((1 << (4 - off)) - 1);
                p_pc   = exp_fpc;
                pend   = 1'b1;
            end
        end
        if (icache_req_valid && icache_req_ready && !outst) begin
            if (!redirect_valid)
                check_val("req_addr", icache_req_addr, {exp_fpc[63:4], 4'h0});
            last_hs_addr = icache_req_addr;
            hs_count++;
            outst   = 1'b1;
            live    = !redirect_valid;
            due_cyc = cyc + $urandom_range(lat_lo, lat_hi);
            rdata   = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        end
        if (redirect_valid)
            exp_fpc = redirect_target;
    endtask

    task automatic run_cycle();
        @(posedge clock);
        #1;
        drive_inputs();
        @(negedge clock);
        observe();
        cyc++;
        force_redir = 1'b0;
    endtask

    task automatic wait_deliveries(input int n, input int budget, input string tag);
        int start;
        int i;
        start = deliv_count;
        i = 0;
        while (deliv_count < start + n && i < budget) begin
            run_cycle();
            i++;
        end
        check_val(tag, deliv_count >= start + n, 1'b1);
    endtask

    task automatic wait_handshake(input int budget, input string tag);
        int start;
        int i;
        start = hs_count;
        i = 0;
        while (hs_count == start && i < budget) begin
            run_cycle();
            i++;
        end
        check_val(tag, hs_count > start, 1'b1);
    endtask

    task automatic model_reset();
        outst = 1'b0; live = 1'b0; pend = 1'b0;
        exp_fpc = RESET_PC;
        last_deliv = -1000;
    endtask

    initial begin
        reset_n = 1'b0;
        fetch_inst = 1'b0; redirect_valid = 1'b0; redirect_target = 64'd0;
        icache_req_ready = 1'b0; icache_resp_valid = 1'b0; icache_resp_data = '0;
        cyc = 0; deliv_count = 0; hs_count = 0; due_cyc = 0;
        rdata = '0; p_instr = '0; p_mask = 4'b0000; p_pc = 64'd0; last_hs_addr = 64'd0;
        redir_pct = 0; lat_lo = 2; lat_hi = 2; calm = 1'b1; force_redir = 1'b0; force_tgt = 64'd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_req_valid", icache_req_valid, 1'b0);
        check_val("rst_req_addr", icache_req_addr, 64'd0);
        check_val("rst_instr", aligned_instr, 128'd0);
        check_val("rst_valid", aligned_instr_valid, 4'b0000);
        check_val("rst_pc", pc, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // First line from RESET_PC, then the sequential next line.
        wait_handshake(20, "first_req_seen");
        check_val("first_req_addr", last_hs_addr, RESET_PC);
        wait_deliveries(1, 30, "first_delivery");
        wait_handshake(30, "second_req_seen");
        check_val("second_req_addr", last_hs_addr, RESET_PC + 64'h10);
        wait_deliveries(1, 30, "second_delivery");

        // Redirect while idle to a mid-line target.
        force_redir = 1'b1; force_tgt = 64'h0000_0000_8000_0108;
        run_cycle();
        wait_handshake(30, "redir_idle_req_seen");
        check_val("redir_idle_req_addr", last_hs_addr, 64'h0000_0000_8000_0100);
        wait_deliveries(1, 30, "redir_idle_delivery");
        check_val("redir_idle_next_fpc", exp_fpc, 64'h0000_0000_8000_0110);

        // Redirect while waiting for a slow response.
        lat_lo = 3; lat_hi = 3;
        wait_handshake(30, "pre_wait_req_seen");
        force_redir = 1'b1; force_tgt = 64'h0000_0000_9000_0004;
        run_cycle();
        wait_handshake(30, "redir_wait_req_seen");
        check_val("redir_wait_req_addr", last_hs_addr, 64'h0000_0000_9000_0000);
        wait_deliveries(1, 30, "redir_wait_delivery");

        // Randomized traffic with redirects, stalls and variable latency.
        calm = 1'b0; redir_pct = 6; lat_lo = 1; lat_hi = 4;
        repeat (1500) run_cycle();
        check_val("random_deliveries", deliv_count >= 60, 1'b1);

        // Asynchronous reset while a request is in flight.
        calm = 1'b1; redir_pct = 0; lat_lo = 6; lat_hi = 6;
        wait_deliveries(1, 60, "pre_reset_delivery");
        wait_handshake(40, "pre_reset_req_seen");
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("async_req_valid", icache_req_valid, 1'b0);
        check_val("async_req_addr", icache_req_addr, 64'd0);
        check_val("async_instr", aligned_instr, 128'd0);
        check_val("async_pc", pc, 64'd0);
        check_val("async_valid", aligned_instr_valid, 4'b0000);
        icache_resp_valid = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        lat_lo = 1; lat_hi = 2;
        wait_handshake(20, "post_reset_req_seen");
        check_val("post_reset_req_addr", last_hs_addr, RESET_PC);
        wait_deliveries(2, 60, "post_reset_deliveries");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
